uart_char_tx: RTL and testbench

UART character transmitter. It is the sending end of the serial link whose receive side is monitored by the per-character strobe/interrupt detector. It accepts bytes over a valid/ready handshake and serialises them LSB-first with start bit, optional parity and stop bits. An enforced idle gap after each character lets the far-end character detector separate consecutive characters.

---
 rtl/uart_char_tx.sv | 154 +++++++++++++++
 tb/tb_uart_char_tx.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/uart_char_tx.sv
// UART character transmitter: start bit, 8 data bits LSB-first, optional parity,
// stop bit(s) and an optional idle gap so the far-end detector can separate characters.
module uart_char_tx #(
  parameter int unsigned CW        = 16,
  parameter int unsigned CLK_DIV   = 868,
  parameter int unsigned STOP_BITS = 1,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned GAP_BITS  = 0,
  parameter logic        POLARITY  = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       tx_o,
  output logic       busy_o,
  output logic       done_o
);

  // Handshake: a byte transfers on the rising edge where valid_i && ready_o;
  // ready_o is high only in IDLE, so valid_i/data_i are don't-care while busy.

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_GAP
  } state_t;

  localparam logic [CW-1:0] BAUD_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(7);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_BITS == 0) ? 0 : GAP_BITS - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [CW-1:0] bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic          tx_q, tx_d;
  logic          done_q, done_d;
  logic          bit_end;

  function automatic logic line_level(input logic b);
    return ~(b ^ POLARITY);
  endfunction

  assign bit_end = (baud_q == BAUD_LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= POLARITY;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    if (state_q != S_IDLE) baud_d = bit_end ? '0 : baud_q + 1'b1;
    case (state_q)
      S_IDLE: begin
        if (valid_i) begin
          state_d = S_START;
          shift_d = data_i;
          par_d   = (PARITY == 2) ? ~^data_i : ^data_i;
          tx_d    = ~POLARITY;
          baud_d  = '0;
          bit_d   = '0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          tx_d    = line_level(shift_q[0]);
        end
      end
      // Shift register always presents the current bit at [0]; [1] is the next one.
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
            if (PARITY != 0) begin
              state_d = S_PARITY;
              tx_d    = line_level(par_q);
            end else begin
              state_d = S_STOP;
              tx_d    = POLARITY;
            end
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
            tx_d    = line_level(shift_q[1]);
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          tx_d    = POLARITY;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (bit_q == STOP_LAST) begin
            bit_d = '0;
            if (GAP_BITS != 0) begin
              state_d = S_GAP;
            end else begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      S_GAP: begin
        if (bit_end) begin
          if (bit_q == GAP_LAST) begin
            bit_d   = '0;
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ready_o = (state_q == S_IDLE);
  assign busy_o  = ~ready_o;
  assign tx_o    = tx_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_uart_char_tx.sv
// Bench for uart_char_tx: five configurations side by side, each checked every cycle
// against a frame-level reference model, plus a serial decode scoreboard per instance.
module tb_uart_char_tx;

  localparam int NI = 5;
  localparam int CD = 4;
  localparam int unsigned P_PAR  [NI] = '{0, 1, 2, 0, 0};
  localparam int unsigned P_STOP [NI] = '{1, 1, 1, 2, 1};
  localparam int unsigned P_GAP  [NI] = '{0, 0, 0, 2, 0};
  localparam bit          P_POL  [NI] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    data [NI];
  logic [NI-1:0] valid = '0;
  logic [NI-1:0] ready, tx, busy, done;

  int checks = 0;
  int errors = 0;

  // reference model state, updated on rising edges
  bit         m_idle [NI] = '{default: 1'b1};
  bit         m_done [NI] = '{default: 1'b0};
  int         m_t    [NI] = '{default: 0};
  logic [7:0] m_byte [NI];
  int         acc_cnt  [NI] = '{default: 0};
  int         exp_done [NI] = '{default: 0};
  int         dut_done [NI] = '{default: 0};
  logic [7:0] rx_byte  [NI];
  logic [7:0] exp_q    [NI][$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    uart_char_tx #(
      .CW(16), .CLK_DIV(CD), .STOP_BITS(P_STOP[g]), .PARITY(P_PAR[g]),
      .GAP_BITS(P_GAP[g]), .POLARITY(P_POL[g])
    ) u_dut (
      .clk_i(clk), .rst_i(rst), .data_i(data[g]), .valid_i(valid[g]),
      .ready_o(ready[g]), .tx_o(tx[g]), .busy_o(busy[g]), .done_o(done[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int frame_cycles(input int i);
    return (1 + 8 + ((P_PAR[i] != 0) ? 1 : 0) + int'(P_STOP[i]) + int'(P_GAP[i])) * CD;
  endfunction

  // logical value of bit-time k of a frame carrying byte b
  function automatic logic frame_bit(input int i, input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (P_PAR[i] != 0 && k == 9) return (P_PAR[i] == 1) ? ^b : ~^b;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        m_idle[i] <= 1'b1;
        m_done[i] <= 1'b0;
        exp_q[i].delete();
      end else if (m_idle[i]) begin
        m_done[i] <= 1'b0;
        if (valid[i]) begin
          m_idle[i]  <= 1'b0;
          m_t[i]     <= 0;
          m_byte[i]  <= data[i];
          acc_cnt[i] <= acc_cnt[i] + 1;
          exp_q[i].push_back(data[i]);
        end
      end else if (m_t[i] + 1 == frame_cycles(i)) begin
        m_idle[i]   <= 1'b1;
        m_done[i]   <= 1'b1;
        exp_done[i] <= exp_done[i] + 1;
      end else begin
        m_t[i] <= m_t[i] + 1;
      end
    end
  end

  always @(negedge clk) begin
    logic exp_tx;
    int   k;
    for (int i = 0; i < NI; i++) begin
      k = m_t[i] / CD;
      exp_tx = m_idle[i] ? P_POL[i] : ~(frame_bit(i, m_byte[i], k) ^ P_POL[i]);
      check($sformatf("tx[%0d]", i), 32'(tx[i]), 32'(exp_tx));
      check($sformatf("ready[%0d]", i), 32'(ready[i]), 32'(m_idle[i]));
      check($sformatf("busy[%0d]", i), 32'(busy[i]), 32'(!m_idle[i]));
      check($sformatf("done[%0d]", i), 32'(done[i]), 32'(m_done[i]));
      if (done[i]) dut_done[i]++;
      if (!m_idle[i] && (m_t[i] % CD) == CD / 2 && k >= 1 && k <= 8)
        rx_byte[i][k-1] = ~(tx[i] ^ P_POL[i]);
      if (m_done[i] && exp_q[i].size() > 0)
        check($sformatf("rx_byte[%0d]", i), 32'(rx_byte[i]), 32'(exp_q[i].pop_front()));
    end
  end

  task automatic wait_accept(input int i, input int a0);
    for (int n = 0; n < 200 && acc_cnt[i] == a0; n++) @(negedge clk);
    if (acc_cnt[i] == a0) check($sformatf("accept_timeout[%0d]", i), 32'(acc_cnt[i]), 32'(a0 + 1));
  endtask

  task automatic wait_idle(input int i);
    for (int n = 0; n < 200 && !m_idle[i]; n++) @(negedge clk);
    if (!m_idle[i]) check($sformatf("idle_timeout[%0d]", i), 32'(m_idle[i]), 32'(1));
  endtask

  // send one byte; with churn, valid/data toggle randomly while the frame is in flight
  task automatic send(input int i, input logic [7:0] b, input bit churn);
    int a0;
    a0 = acc_cnt[i];
    @(negedge clk);
    data[i]  = b;
    valid[i] = 1'b1;
    wait_accept(i, a0);
    valid[i] = 1'b0;
    for (int n = 0; n < 200 && !m_idle[i]; n++) begin
      @(negedge clk);
      if (churn && !m_idle[i]) begin
        valid[i] = 1'($urandom_range(0, 1));
        data[i]  = 8'($urandom);
      end else begin
        valid[i] = 1'b0;
      end
    end
  endtask

  initial begin
    int a0;
    for (int i = 0; i < NI; i++) data[i] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    send(0, 8'h55, 1'b0);
    send(1, 8'h07, 1'b0);
    send(2, 8'h07, 1'b0);
    send(4, 8'h01, 1'b0);

    // back-to-back with valid held high through the gap
    a0 = acc_cnt[3];
    @(negedge clk);
    data[3]  = 8'hA3;
    valid[3] = 1'b1;
    wait_accept(3, a0);
    data[3] = 8'h3C;
    wait_accept(3, a0 + 1);
    valid[3] = 1'b0;
    wait_idle(3);

    // reset in the middle of data bit 3
    a0 = acc_cnt[0];
    @(negedge clk);
    data[0]  = 8'hC5;
    valid[0] = 1'b1;
    wait_accept(0, a0);
    valid[0] = 1'b0;
    for (int n = 0; n < 100 && m_t[0] != 4 * CD + 1; n++) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_tx", 32'(tx[0]), 32'(P_POL[0]));
    check("rst_ready", 32'(ready[0]), 32'(1));
    check("rst_done", 32'(done[0]), 32'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    send(0, 8'h9E, 1'b0);

    for (int r = 0; r < 8; r++)
      for (int i = 0; i < NI; i++) begin
        send(i, 8'($urandom), 1'(r % 2));
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end

    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("done_count[%0d]", i), 32'(dut_done[i]), 32'(exp_done[i]));
      check($sformatf("pending[%0d]", i), 32'(exp_q[i].size()), 32'(0));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
